// File: rtl/wb_sram_slave_pkg.sv
// Shared types and constants for the Wishbone SRAM slave.
package wb_sram_slave_pkg;

  localparam int WB_WORD_BYTES = 4;
  localparam int WB_ADR_W      = 32;
  localparam int WB_DAT_W      = WB_WORD_BYTES * 8;
  localparam int WB_SEL_W      = WB_WORD_BYTES;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic                we;
    logic [WB_SEL_W-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 pipelined bus bundle; signal suffixes are from the slave's point of view.
interface wb_sram_slave_if;
  import wb_sram_slave_pkg::*;

  logic [WB_ADR_W-1:0] adr_i;
  logic [WB_DAT_W-1:0] dat_i;
  logic [WB_DAT_W-1:0] dat_o;
  logic                we_i;
  logic [WB_SEL_W-1:0] sel_i;
  logic                stb_i;
  logic                ack_o;
  logic                cyc_i;
  logic                stall_o;

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
    output dat_o, ack_o, stall_o
  );

  modport master (
    output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
    input  dat_o, ack_o, stall_o
  );

endinterface

// File: rtl/wb_sram_slave_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module sp_ram_be
  import wb_sram_slave_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [WB_SEL_W-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic [WB_DAT_W-1:0] rdata_o
);

  logic [WB_DAT_W-1:0] mem_q [DEPTH_WORDS];
  logic [WB_DAT_W-1:0] rdata_q;

  // Read data only updates on a read so it stays stable while later stages sample it.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < WB_SEL_W; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 pipelined SRAM slave: fixed-latency ack pipeline, range check and
// an optional periodic one-cycle stall.
module wb_sram_slave
  import wb_sram_slave_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          LATENCY        = 2,
  parameter int          REFRESH_PERIOD = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_sram_slave_if.slave wb
);

  localparam int AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WORD_SHIFT = $clog2(WB_WORD_BYTES);

  wb_req_t             req;
  logic [31:0]         wordOff;
  logic                inRange;
  logic                stall;
  logic                accept;
  logic [WB_DAT_W-1:0] ramRdata;
  logic [WB_DAT_W-1:0] stage0Data;
  logic [WB_DAT_W-1:0] ackData;
  logic                ack;

  logic [LATENCY-1:0]  valid_q, valid_d;
  logic                readHit_q, readHit_d;

  assign req = '{adr: wb.adr_i, dat: wb.dat_i, we: wb.we_i, sel: wb.sel_i};

  // BASE_ADDR is word aligned, so subtracting word indices equals the byte difference >> 2.
  assign wordOff = (req.adr >> WORD_SHIFT) - (BASE_ADDR >> WORD_SHIFT);
  assign inRange = (req.adr >= BASE_ADDR) && (wordOff < 32'(DEPTH_WORDS));
  assign accept  = wb.stb_i & wb.cyc_i & ~stall;

  sp_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (accept & inRange),
    .we_i    (req.we),
    .be_i    (req.sel),
    .addr_i  (wordOff[AW-1:0]),
    .wdata_i (req.dat),
    .rdata_o (ramRdata)
  );

  always_comb begin
    valid_d   = '0;
    readHit_d = 1'b0;
    if (wb.cyc_i) begin
      valid_d[0] = accept;
      for (int k = 1; k < LATENCY; k++) begin
        valid_d[k] = valid_q[k-1];
      end
      readHit_d = accept & ~req.we & inRange;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      readHit_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      readHit_q <= readHit_d;
    end
  end

  // The RAM output register doubles as the data half of the first stage.
  assign stage0Data = readHit_q ? ramRdata : '0;

  generate
    if (LATENCY == 1) begin : gDirect
      assign ackData = stage0Data;
    end else begin : gDataPipe
      logic [WB_DAT_W-1:0] data_q [LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int k = 0; k < LATENCY-1; k++) begin
            data_q[k] <= '0;
          end
        end else begin
          data_q[0] <= stage0Data;
          for (int k = 1; k < LATENCY-1; k++) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end

      assign ackData = data_q[LATENCY-2];
    end
  endgenerate

  generate
    if (REFRESH_PERIOD > 0) begin : gRefresh
      localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
      localparam logic [CW-1:0] LAST = CW'(REFRESH_PERIOD - 1);

      logic [CW-1:0] count_q, count_d;

      always_comb begin
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          count_d = '0;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign stall = (count_q == LAST);
    end else begin : gNoRefresh
      assign stall = 1'b0;
    end
  endgenerate

  // Gating with cyc_i hides acks in the cycle an abort is signalled.
  assign ack        = valid_q[LATENCY-1] & wb.cyc_i;
  assign wb.ack_o   = ack;
  assign wb.dat_o   = ack ? ackData : '0;
  assign wb.stall_o = stall;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: one unstalled instance and one with periodic stalls.
module tb_wb_sram_slave;

  logic clk = 1'b0;
  logic rst;
  logic rstR;
  int   total = 0;
  int   bad   = 0;

  wb_sram_slave_if bus ();
  wb_sram_slave_if busR ();

  wb_sram_slave #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(2), .REFRESH_PERIOD(0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  wb_sram_slave #(
    .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_2000), .LATENCY(2), .REFRESH_PERIOD(4)
  ) dutR (
    .clk_i (clk),
    .rst_i (rstR),
    .wb    (busR)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.cyc_i = cyc;
    bus.stb_i = stb;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = dat;
    bus.sel_i = sel;
  endtask

  task automatic driveR(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    busR.cyc_i = cyc;
    busR.stb_i = stb;
    busR.we_i  = we;
    busR.adr_i = adr;
    busR.dat_i = dat;
    busR.sel_i = sel;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rstR = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    driveR(0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if ({bus.ack_o, bus.dat_o, bus.stall_o} !== 34'h0) begin
      bad++;
      $display("[TB] FAIL reset_dut: got ack=%b dat=%h stall=%b, want all 0", bus.ack_o, bus.dat_o, bus.stall_o);
    end
    total++;
    if ({busR.ack_o, busR.dat_o, busR.stall_o} !== 34'h0) begin
      bad++;
      $display("[TB] FAIL reset_dutR: got ack=%b dat=%h stall=%b, want all 0", busR.ack_o, busR.dat_o, busR.stall_o);
    end
    tick();
    tick();
    rst  = 1'b0;
    rstR = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.ack_o, bus.dat_o, bus.stall_o} !== 34'h0) begin
      bad++;
      $display("[TB] FAIL reset_release: got ack=%b dat=%h stall=%b, want all 0", bus.ack_o, bus.dat_o, bus.stall_o);
    end
    tick();
  endtask

  task automatic test_basic_rw();
    logic        expAck [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] expDat [5] = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       drive(1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        1:       drive(1, 1, 0, 32'h10, 32'h0, 4'hF);
        default: drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      total++;
      if (bus.ack_o !== expAck[c] || bus.dat_o !== expDat[c]) begin
        bad++;
        $display("[TB] FAIL basic_rw cycle %0d: got ack=%b dat=%h, want ack=%b dat=%h",
                 c, bus.ack_o, bus.dat_o, expAck[c], expDat[c]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_sel_mask();
    logic        expAck [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] expDat [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11BB33DD, 32'h0};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(1, 1, 1, 32'h20, 32'h11223344, 4'b1111);
        1:       drive(1, 1, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        2:       drive(1, 1, 0, 32'h20, 32'h0, 4'b0001);
        default: drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      total++;
      if (bus.ack_o !== expAck[c] || bus.dat_o !== expDat[c]) begin
        bad++;
        $display("[TB] FAIL sel_mask cycle %0d: got ack=%b dat=%h, want ack=%b dat=%h",
                 c, bus.ack_o, bus.dat_o, expAck[c], expDat[c]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
    logic        expAck;
    logic [31:0] expDat;
    for (int c = 0; c < 11; c++) begin
      if (c < 4)      drive(1, 1, 1, 32'(4*c), words[c], 4'hF);
      else if (c < 8) drive(1, 1, 0, 32'(4*(c-4)), 32'h0, 4'hF);
      else            drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
      expAck = (c >= 2) && (c <= 9);
      expDat = (c >= 6 && c <= 9) ? words[c-6] : 32'h0;
      @(negedge clk);
      total++;
      if (bus.ack_o !== expAck || bus.dat_o !== expDat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("[TB] FAIL back_to_back cycle %0d: got ack=%b dat=%h stall=%b, want ack=%b dat=%h stall=0",
                 c, bus.ack_o, bus.dat_o, bus.stall_o, expAck, expDat);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    logic        expAck [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] expDat [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0BADCAFE, 32'h0};
    for (int c = 0; c < 12; c++) begin
      case (c)
        0:       drive(1, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF);
        1:       drive(1, 1, 1, 32'h44, 32'h0BADCAFE, 4'hF);
        5, 6:    drive(1, 1, 0, 32'h40, 32'h0, 4'hF);
        7:       drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        8:       drive(1, 1, 0, 32'h44, 32'h0, 4'hF);
        default: drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      total++;
      if (bus.ack_o !== expAck[c] || bus.dat_o !== expDat[c]) begin
        bad++;
        $display("[TB] FAIL abort cycle %0d: got ack=%b dat=%h, want ack=%b dat=%h",
                 c, bus.ack_o, bus.dat_o, expAck[c], expDat[c]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_refresh_stall();
    int   accepts = 0;
    int   acks    = 0;
    logic expStall;
    logic expAck;
    rstR = 1'b1;
    tick();
    rstR = 1'b0;
    for (int c = 0; c < 18; c++) begin
      driveR(1, (c < 12), 1, 32'h2000, 32'h5555_0000 | 32'(c), 4'hF);
      expStall = ((c % 4) == 3);
      expAck   = (c >= 2) && (c - 2 < 12) && (((c - 2) % 4) != 3);
      @(negedge clk);
      total++;
      if (busR.stall_o !== expStall || busR.ack_o !== expAck) begin
        bad++;
        $display("[TB] FAIL refresh cycle %0d: got stall=%b ack=%b, want stall=%b ack=%b",
                 c, busR.stall_o, busR.ack_o, expStall, expAck);
      end
      if (busR.stb_i && busR.cyc_i && !busR.stall_o) accepts++;
      if (busR.ack_o) acks++;
      tick();
    end
    total++;
    if (accepts !== 9 || acks !== 9) begin
      bad++;
      $display("[TB] FAIL refresh_counts: got accepts=%0d acks=%0d, want 9 and 9", accepts, acks);
    end
    driveR(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_base_window();
    logic        expAck [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] expDat [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h600DF00D, 32'h0};
    rstR = 1'b1;
    tick();
    rstR = 1'b0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       driveR(1, 1, 1, 32'h2004, 32'h600DF00D, 4'hF);
        1:       driveR(1, 1, 0, 32'h1FFC, 32'h0, 4'hF);
        2:       driveR(1, 1, 0, 32'h2040, 32'h0, 4'hF);
        4:       driveR(1, 1, 0, 32'h2004, 32'h0, 4'hF);
        default: driveR(1, 0, 0, 32'h0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      total++;
      if (busR.ack_o !== expAck[c] || busR.dat_o !== expDat[c] || busR.stall_o !== ((c % 4) == 3)) begin
        bad++;
        $display("[TB] FAIL base_window cycle %0d: got ack=%b dat=%h stall=%b, want ack=%b dat=%h",
                 c, busR.ack_o, busR.dat_o, busR.stall_o, expAck[c], expDat[c]);
      end
      tick();
    end
    driveR(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    logic        expAck [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] expDat [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1000_0001, 32'h0};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(1, 1, 1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        1:       drive(1, 1, 0, 32'h1000, 32'h0, 4'hF);
        2:       drive(1, 1, 0, 32'h0, 32'h0, 4'hF);
        default: drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      total++;
      if (bus.ack_o !== expAck[c] || bus.dat_o !== expDat[c]) begin
        bad++;
        $display("[TB] FAIL out_of_range cycle %0d: got ack=%b dat=%h, want ack=%b dat=%h",
                 c, bus.ack_o, bus.dat_o, expAck[c], expDat[c]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    drive(1, 1, 1, 32'h80, 32'h12345678, 4'hF);
    tick();
    drive(1, 1, 0, 32'h80, 32'h0, 4'hF);
    tick();
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    #2;
    total++;
    if (bus.ack_o !== 1'b1 || bus.dat_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL async_pre_reset: got ack=%b dat=%h, want ack=1 dat=00000000", bus.ack_o, bus.dat_o);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.ack_o !== 1'b0 || bus.dat_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL async_in_reset: got ack=%b dat=%h, want ack=0 dat=00000000", bus.ack_o, bus.dat_o);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ack_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_lost_ack: got ack=%b, want ack=0", bus.ack_o);
    end
    tick();
    drive(1, 1, 0, 32'h80, 32'h0, 4'hF);
    tick();
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    total++;
    if (bus.ack_o !== 1'b1 || bus.dat_o !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL async_persist: got ack=%b dat=%h, want ack=1 dat=12345678", bus.ack_o, bus.dat_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_sel_mask();
    test_back_to_back();
    test_abort();
    test_refresh_stall();
    test_base_window();
    test_out_of_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
